multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 2, SHALL set ALUControl width; legal values 2 (ADD/SUB/AND/ORR) and 3 (adds EOR and CMP).
REQ-002 Parameter FLAGS_RST, default 4'b0000, SHALL be the {N,Z,C,V} flag register reset value.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 Cond  in  4  Instr[31:28]; Op  in  2  Instr[27:26]; Funct  in  6  Instr[25:20]; Rd  in  4  Instr[15:12].
REQ-006 ALUFlags  in  4  {N,Z,C,V} from the datapath ALU, sampled in execute states.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  out  1 each  datapath enables/selects.
REQ-008 ResultSrc, ALUSrcB, ImmSrc, RegSrc  out  2 each; ALUControl  out  ALUCTRL_W.
REQ-009 State  out  4  current FSM state code, for debug and bench observation.

Function
REQ-010 The FSM SHALL have states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, HOLD=10; other codes SHALL go to FETCH next cycle.
REQ-011 Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECI (Op=00, Funct[5]=1), EXECR (Op=00, Funct[5]=0), BRANCH (Op=10), FETCH (Op=11).
REQ-012 Transitions: MEMADR->MEMRD (Funct[0]=1) or MEMWR (Funct[0]=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-013 Latency: branch 3 cycles, store 4, data-processing 4, load 5.
REQ-014 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD, PCWrite=1 unconditionally.
REQ-015 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD; no enables asserted.
REQ-016 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; MEMRD: AdrSrc=1, ResultSrc=00; MEMWR: AdrSrc=1, MemWrite=CondEx; MEMWB: ResultSrc=01, RegWrite=CondEx.
REQ-017 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01; both drive decoded ALUControl.
REQ-018 ALUWB: ResultSrc=00, RegWrite=CondEx&~NoWrite, PCWrite=CondEx&(Rd=15).
REQ-019 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx.
REQ-020 Decode of Funct[4:1]: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3; with ALUCTRL_W=3 also 0001 EOR=4, 1010 CMP=SUB with NoWrite=1.
REQ-021 Unsupported command SHALL drive ALUControl=0 and suppress RegWrite, PCWrite and flag update in ALUWB (NOP).
REQ-022 ImmSrc SHALL equal Op; RegSrc[0]=(Op=10), RegSrc[1]=(Op=01), combinationally in all states.
REQ-023 CondEx SHALL be the ARM condition (EQ..AL, 0000-1110) evaluated on the registered flags; Cond=1111 SHALL yield CondEx=0.
REQ-024 Flags SHALL update from ALUFlags at the end of EXECR/EXECI only when Funct[0]=1 (or CMP) and CondEx=1: N,Z always; C,V only for ADD/SUB/CMP.
REQ-025 Write enables not listed for a state SHALL be 0; unlisted selects SHALL be 0.

Reset
REQ-026 While RST_N=0: State=FETCH, flags=FLAGS_RST, every output 0 regardless of inputs.
REQ-027 Reset asserted mid-instruction SHALL abort it with no further write enable; first cycle after release SHALL present FETCH outputs.

Configuration
REQ-028 Macro HOST_HOLD_EN SHALL add ports HostReq (in, 1) and HostAck (out, 1) for host loading of data memory.
REQ-029 With HOST_HOLD_EN: FETCH with HostReq=1 SHALL go to HOLD instead of DECODE with IRWrite and PCWrite forced 0; HOLD drives HostAck=1, all enables 0, stays while HostReq=1, returns to FETCH when HostReq=0; HostAck=0 in reset.
REQ-030 Without HOST_HOLD_EN: ports absent, HOLD unreachable, FETCH->DECODE always.

Verification
REQ-031 Reset, then Op=00, Funct=101001 (ADDS imm), Cond=1110, ALUFlags=0100 -> States 0,1,7,8,0; Z=1 after EXECI; RegWrite=1 only in ALUWB.
REQ-032 Flags Z=1, Op=10, Cond=0001 (NE) -> BRANCH entered, PCWrite=0 in BRANCH; with Cond=0000 -> PCWrite=1.
REQ-033 Op=01, Funct[0]=1 (LDR) -> States 0,1,2,3,4; AdrSrc=1 in MEMRD; RegWrite=1 in MEMWB; ResultSrc=01.
REQ-034 ALUCTRL_W=3, Funct=110101 (CMP) -> ALUControl=1, flags updated, RegWrite=0 in ALUWB; ALUCTRL_W=2 same input -> NOP, flags unchanged.
REQ-035 RST_N low during MEMWR -> MemWrite drops to 0 immediately; after release State=0.
REQ-036 HOST_HOLD_EN, HostReq=1 in FETCH for 5 cycles -> State=10, HostAck=1, all enables 0; HostReq=0 -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle ARM-subset control FSM with {N,Z,C,V} flag register
// Optional feature: `define HOST_HOLD_EN adds HostReq/HostAck and the HOLD state for host memory loading.
module multicycle_control_unit #(
  parameter int         ALUCTRL_W = 2,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
`ifdef HOST_HOLD_EN
  input  logic                 HostReq,
  output logic                 HostAck,
`endif
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, HOLD = 4'd10
  } state_t;

  state_t                 state_q, state_d;
  logic   [3:0]           flags;
  logic                   condex, supported, nowrite, is_arith, flag_upd;
  logic   [ALUCTRL_W-1:0] alu_sel;

  always_comb begin
    alu_sel   = '0;
    nowrite   = 1'b0;
    supported = 1'b1;
    is_arith  = 1'b0;
    case (Funct[4:1])
      4'b0100: is_arith = 1'b1;
      4'b0010: begin alu_sel = ALUCTRL_W'(1); is_arith = 1'b1; end
      4'b0000: alu_sel = ALUCTRL_W'(2);
      4'b1100: alu_sel = ALUCTRL_W'(3);
      4'b0001: if (ALUCTRL_W >= 3) alu_sel = ALUCTRL_W'(4); else supported = 1'b0;
      // CMP reuses the subtractor but never writes a register
      4'b1010: if (ALUCTRL_W >= 3) begin
                 alu_sel  = ALUCTRL_W'(1);
                 is_arith = 1'b1;
                 nowrite  = 1'b1;
               end else supported = 1'b0;
      default: supported = 1'b0;
    endcase
  end

  always_comb begin
    case (Cond)
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = (flags[3] == flags[0]);
      4'b1011: condex = (flags[3] != flags[0]);
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  assign flag_upd = ((state_q == EXECR) || (state_q == EXECI)) && supported &&
                    (Funct[0] || nowrite) && condex;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FETCH;
      flags   <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      if (flag_upd) begin
        flags[3:2] <= ALUFlags[3:2];
        if (is_arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
`ifdef HOST_HOLD_EN
    HostAck    = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = DECODE;
`ifdef HOST_HOLD_EN
        if (HostReq) begin
          IRWrite = 1'b0;
          PCWrite = 1'b0;
          state_d = HOLD;
        end
`endif
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex;
      end
      EXECR: begin
        ALUControl = alu_sel;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_sel;
        state_d    = ALUWB;
      end
      ALUWB: begin
        RegWrite = condex & ~nowrite & supported;
        PCWrite  = condex & (Rd == 4'd15) & supported;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex;
      end
`ifdef HOST_HOLD_EN
      HOLD: begin
        HostAck = 1'b1;
        state_d = HostReq ? HOLD : FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
    // Outputs are forced low combinationally so an abort takes effect before the next edge
    if (!RST_N) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
`ifdef HOST_HOLD_EN
      HostAck    = 1'b0;
`endif
    end
  end

  assign ImmSrc = RST_N ? Op : 2'b00;
  assign RegSrc = RST_N ? {(Op == 2'b01), (Op == 2'b10)} : 2'b00;
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table, directed and random checks of multicycle_control_unit (ALUCTRL_W=2 and 3)
// Define HOST_HOLD_EN to also exercise the host hold feature.
module tb_multicycle_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
  localparam int S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9, S_HOLD = 10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] Cond = 4'd0, Rd = 4'd0, ALUFlags = 4'd0;
  logic [1:0] Op = 2'd0;
  logic [5:0] Funct = 6'd0;
  logic       HostReq = 1'b0;

  logic       pcw2, irw2, rw2, mw2, adr2, asa2, pcw3, irw3, rw3, mw3, adr3, asa3;
  logic [1:0] rs2, bsb2, imm2, rsrc2, rs3, bsb3, imm3, rsrc3, alu2;
  logic [2:0] alu3;
  logic [3:0] st2, st3;
  logic       ack2, ack3;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.ALUCTRL_W(2), .FLAGS_RST(4'b0000)) u2 (
    .CLK(CLK), .RST_N(RST_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
`ifdef HOST_HOLD_EN
    .HostReq(HostReq), .HostAck(ack2),
`endif
    .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2), .AdrSrc(adr2), .ALUSrcA(asa2),
    .ResultSrc(rs2), .ALUSrcB(bsb2), .ImmSrc(imm2), .RegSrc(rsrc2), .ALUControl(alu2), .State(st2));

  multicycle_control_unit #(.ALUCTRL_W(3), .FLAGS_RST(4'b0000)) u3 (
    .CLK(CLK), .RST_N(RST_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
`ifdef HOST_HOLD_EN
    .HostReq(HostReq), .HostAck(ack3),
`endif
    .PCWrite(pcw3), .IRWrite(irw3), .RegWrite(rw3), .MemWrite(mw3), .AdrSrc(adr3), .ALUSrcA(asa3),
    .ResultSrc(rs3), .ALUSrcB(bsb3), .ImmSrc(imm3), .RegSrc(rsrc3), .ALUControl(alu3), .State(st3));

`ifndef HOST_HOLD_EN
  assign ack2 = 1'b0;
  assign ack3 = 1'b0;
`endif

  logic [20:0] obs2, obs3;
  assign obs2 = {st2, pcw2, irw2, rw2, mw2, adr2, asa2, rs2, bsb2, imm2, rsrc2, 1'b0, alu2};
  assign obs3 = {st3, pcw3, irw3, rw3, mw3, adr3, asa3, rs3, bsb3, imm3, rsrc3, alu3};

  int total = 0, bad = 0;
  logic [3:0] mflags [2];
  int seq3[$], pcw2q[$], pcw3q[$], rw3q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;          4'd1:  return !z;
      4'd2:  return cy;         4'd3:  return !cy;
      4'd4:  return n;          4'd5:  return !n;
      4'd6:  return v;          4'd7:  return !v;
      4'd8:  return cy && !z;   4'd9:  return !cy || z;
      4'd10: return n == v;     4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU command table: code, whether it is supported at this width, CMP-style no-write, sets C/V
  function automatic void dec(input int w, input logic [3:0] f4, output bit sup, output int code,
                              output bit nw, output bit ar);
    sup = 1; code = 0; nw = 0; ar = 0;
    if      (f4 == 4'b0100) ar = 1;
    else if (f4 == 4'b0010) begin code = 1; ar = 1; end
    else if (f4 == 4'b0000) code = 2;
    else if (f4 == 4'b1100) code = 3;
    else if (w == 3 && f4 == 4'b0001) code = 4;
    else if (w == 3 && f4 == 4'b1010) begin code = 1; ar = 1; nw = 1; end
    else sup = 0;
  endfunction

  function automatic logic [20:0] expect_out(input int w, input int st, input logic [3:0] cond,
      input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] f);
    logic pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, asa = 0;
    logic [1:0] rs = 0, bsb = 0;
    logic [2:0] ac = 0;
    logic [3:0] s4;
    bit sup, nw, ar, ce;
    int code;
    ce = cond_ok(cond, f);
    dec(w, funct[4:1], sup, code, nw, ar);
    s4 = 4'(st);
    case (st)
      S_FETCH:  begin pcw = 1; irw = 1; asa = 1; bsb = 2'b10; rs = 2'b10; end
      S_DECODE: begin asa = 1; bsb = 2'b10; rs = 2'b10; end
      S_MEMADR: bsb = 2'b01;
      S_MEMRD:  adr = 1;
      S_MEMWR:  begin adr = 1; mw = ce; end
      S_MEMWB:  begin rs = 2'b01; rw = ce; end
      S_EXECR:  ac = 3'(code);
      S_EXECI:  begin bsb = 2'b01; ac = 3'(code); end
      S_ALUWB:  begin rw = ce && !nw && sup; pcw = ce && rd == 4'd15 && sup; end
      S_BRANCH: begin bsb = 2'b01; rs = 2'b10; pcw = ce; end
      default:  ;
    endcase
    return {s4, pcw, irw, rw, mw, adr, asa, rs, bsb, op, (op == 2'b01), (op == 2'b10), ac};
  endfunction

  // One whole instruction starting in FETCH at posedge+1, checked cycle by cycle on both widths
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] af);
    int path[$];
    bit sup, nw, ar;
    int code;
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af;
    path = '{S_FETCH, S_DECODE};
    if (op == 2'b01) begin
      path.push_back(S_MEMADR);
      if (funct[0]) begin path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
      else path.push_back(S_MEMWR);
    end else if (op == 2'b00) begin
      path.push_back(funct[5] ? S_EXECI : S_EXECR);
      path.push_back(S_ALUWB);
    end else if (op == 2'b10) path.push_back(S_BRANCH);
    seq3.delete(); pcw2q.delete(); pcw3q.delete(); rw3q.delete();
    foreach (path[k]) begin
      @(negedge CLK);
      chk("w2_cycle", 32'(obs2), 32'(expect_out(2, path[k], cond, op, funct, rd, mflags[0])));
      chk("w3_cycle", 32'(obs3), 32'(expect_out(3, path[k], cond, op, funct, rd, mflags[1])));
      seq3.push_back(int'(st3)); pcw2q.push_back(int'(pcw2));
      pcw3q.push_back(int'(pcw3)); rw3q.push_back(int'(rw3));
      if (path[k] == S_EXECR || path[k] == S_EXECI) begin
        for (int i = 0; i < 2; i++) begin
          dec(i + 2, funct[4:1], sup, code, nw, ar);
          if (sup && (funct[0] || nw) && cond_ok(cond, mflags[i])) begin
            mflags[i][3:2] = af[3:2];
            if (ar) mflags[i][1:0] = af[1:0];
          end
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  af;
    int          len;
    logic [19:0] states;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, 4, 20'h01780}; // ADDS imm
    vt[1] = '{4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 5, 20'h01234}; // LDR
    vt[2] = '{4'hE, 2'b01, 6'b011000, 4'd3,  4'b0000, 4, 20'h01250}; // STR
    vt[3] = '{4'hE, 2'b00, 6'b011000, 4'd4,  4'b1000, 4, 20'h01680}; // ORR reg
    vt[4] = '{4'hE, 2'b10, 6'b100000, 4'd0,  4'b0000, 3, 20'h01900}; // B
    vt[5] = '{4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2, 20'h01000}; // Op=11
    vt[6] = '{4'hE, 2'b00, 6'b110101, 4'd0,  4'b0100, 4, 20'h01780}; // CMP imm
    vt[7] = '{4'hE, 2'b00, 6'b000100, 4'd15, 4'b0011, 4, 20'h01680}; // SUB reg to PC
    mflags[0] = 4'b0000;
    mflags[1] = 4'b0000;

    // Reset holds every output low whatever the inputs
    for (int i = 0; i < 4; i++) begin
      Cond = 4'($urandom); Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom);
      ALUFlags = 4'($urandom); HostReq = 1'($urandom);
      @(negedge CLK);
      chk("reset_w2", 32'(obs2), 32'd0);
      chk("reset_w3", 32'(obs3), 32'd0);
      chk("reset_ack", {ack2, ack3}, 32'd0);
    end
    HostReq = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;

    foreach (vt[i]) begin
      run_instr(vt[i].cond, vt[i].op, vt[i].funct, vt[i].rd, vt[i].af);
      chk("tbl_len", seq3.size(), vt[i].len);
      for (int k = 0; k < vt[i].len && k < seq3.size(); k++)
        chk("tbl_state", seq3[k], 32'(vt[i].states[19 - 4*k -: 4]));
    end

    // ADDS setting Z, then EQ branch taken and NE branch not taken
    run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0100);
    chk("adds_rw_decode", rw3q[1], 0);
    chk("adds_rw_aluwb", rw3q[3], 1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("beq_taken", pcw3q[2], 1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("bne_state", seq3[2], S_BRANCH);
    chk("bne_not_taken", pcw3q[2], 0);

    // CMP: updates flags only on the 3-bit build
    run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0000);
    run_instr(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100);
    chk("cmp_no_regwrite", rw3q[3], 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("cmp_w3_flags", pcw3q[2], 1);
    chk("cmp_w2_nop_flags", pcw2q[2], 0);

    // Reset during MEMWR aborts the store immediately
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; ALUFlags = 4'd0;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    chk("memwr_state", st3, S_MEMWR);
    chk("memwr_we", mw3, 1);
    RST_N = 1'b0;
    #1;
    chk("abort_we", {mw2, mw3}, 0);
    chk("abort_state", st3, S_FETCH);
    mflags[0] = 4'b0000;
    mflags[1] = 4'b0000;
    @(posedge CLK); #1;
    chk("abort_hold_w3", 32'(obs3), 0);
    RST_N = 1'b1;
    #1;
    chk("release_fetch", 32'(obs3), 32'(expect_out(3, S_FETCH, 4'hE, 2'b01, 6'b011000, 4'd0, 4'd0)));

`ifdef HOST_HOLD_EN
    HostReq = 1'b1;
    @(negedge CLK);
    chk("hold_fetch_irw_pcw", {irw3, pcw3, irw2, pcw2}, 0);
    chk("hold_fetch_ack", ack3, 0);
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_state", st3, S_HOLD);
      chk("hold_ack", {ack2, ack3}, 2'b11);
      chk("hold_enables", {pcw3, irw3, rw3, mw3, pcw2, irw2, rw2, mw2}, 0);
      @(posedge CLK); #1;
    end
    HostReq = 1'b0;
    @(negedge CLK);
    chk("hold_last", st3, S_HOLD);
    @(posedge CLK); #1;
    chk("hold_exit_state", st3, S_FETCH);
    chk("hold_exit_ack", ack3, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [3:0] rd_r;
      rd_r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom), 2'($urandom), 6'($urandom),
                rd_r, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
